// File: rtl/alu_issue_ctrl.sv
// ALU reservation station: dispatch into lowest free slot, tag wakeup with same-cycle bypass, one issue per cycle.
// Define ISSUE_OLDEST_EN to issue the oldest eligible entry via an age matrix; default issues the lowest index.
module alu_issue_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        iCLR,
  input  logic        iDP_en,
  input  logic [31:0] iDP_pc,
  input  logic [5:0]  iDP_op,
  input  logic [31:0] iDP_imm,
  input  logic [3:0]  iDP_rd_nick,
  input  logic        iDP_rs1_rdy,
  input  logic [31:0] iDP_rs1_dt,
  input  logic [3:0]  iDP_rs1_nick,
  input  logic        iDP_rs2_rdy,
  input  logic [31:0] iDP_rs2_dt,
  input  logic [3:0]  iDP_rs2_nick,
  input  logic        iEX_en,
  input  logic [3:0]  iEX_nick,
  input  logic [31:0] iEX_dt,
  input  logic        iLSB_en,
  input  logic [3:0]  iLSB_nick,
  input  logic [31:0] iLSB_dt,
  output logic        oRS_full,
  output logic        oRS_en,
  output logic [31:0] oRS_pc,
  output logic [5:0]  oRS_op,
  output logic [31:0] oRS_imm,
  output logic [3:0]  oRS_rd_nick,
  output logic [31:0] oRS_rs1_dt,
  output logic [31:0] oRS_rs2_dt
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] s1_rdy;
  logic [DEPTH-1:0] s2_rdy;
  logic [31:0]      ent_pc  [DEPTH];
  logic [5:0]       ent_op  [DEPTH];
  logic [31:0]      ent_imm [DEPTH];
  logic [3:0]       ent_rd  [DEPTH];
  logic [31:0]      s1_dt   [DEPTH];
  logic [3:0]       s1_tag  [DEPTH];
  logic [31:0]      s2_dt   [DEPTH];
  logic [3:0]       s2_tag  [DEPTH];

  logic [CW-1:0]    occ;
  logic [CW-1:0]    occ_next;

  logic [DEPTH-1:0] s1_wake;
  logic [DEPTH-1:0] s2_wake;
  logic [31:0]      s1_wdt [DEPTH];
  logic [31:0]      s2_wdt [DEPTH];
  logic             dp1_rdy;
  logic             dp2_rdy;
  logic [31:0]      dp1_dt;
  logic [31:0]      dp2_dt;

  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             dp_fire;
  logic [DEPTH-1:0] eligible;
  logic             iss_any;
  logic [IW-1:0]    iss_idx;

  // EX has priority over LSB when both broadcast the same nick.
  function automatic logic bc_hit(input logic [3:0] tag);
    return (iEX_en && (iEX_nick == tag)) || (iLSB_en && (iLSB_nick == tag));
  endfunction

  function automatic logic [31:0] bc_data(input logic [3:0] tag);
    return (iEX_en && (iEX_nick == tag)) ? iEX_dt : iLSB_dt;
  endfunction

  always_comb begin
    s1_wake = '0;
    s2_wake = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s1_wdt[i]  = bc_data(s1_tag[i]);
      s2_wdt[i]  = bc_data(s2_tag[i]);
      s1_wake[i] = ent_valid[i] && !s1_rdy[i] && bc_hit(s1_tag[i]);
      s2_wake[i] = ent_valid[i] && !s2_rdy[i] && bc_hit(s2_tag[i]);
    end
    dp1_rdy = iDP_rs1_rdy || bc_hit(iDP_rs1_nick);
    dp2_rdy = iDP_rs2_rdy || bc_hit(iDP_rs2_nick);
    dp1_dt  = iDP_rs1_rdy ? iDP_rs1_dt : bc_data(iDP_rs1_nick);
    dp2_dt  = iDP_rs2_rdy ? iDP_rs2_dt : bc_data(iDP_rs2_nick);
  end

  // Free slot comes from registered valids, so a slot issued this cycle is not reused until next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign dp_fire  = iDP_en && !oRS_full && free_found;
  assign eligible = ent_valid & s1_rdy & s2_rdy;
  assign iss_any  = |eligible;

`ifdef ISSUE_OLDEST_EN
  // age[j][i] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] pick;

  always_comb begin
    pick = eligible;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && eligible[j] && age[j][i]) begin
          pick[i] = 1'b0;
        end
      end
    end
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) begin
        iss_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
      end
    end else if (rdy && !iCLR && dp_fire) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (IW'(j) != free_idx) begin
          age[j][free_idx] <= 1'b1;
        end
      end
      age[free_idx] <= '0;
    end
  end
`else
  always_comb begin
    iss_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        iss_idx = IW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      s1_rdy    <= '0;
      s2_rdy    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]  <= '0;
        ent_op[i]  <= '0;
        ent_imm[i] <= '0;
        ent_rd[i]  <= '0;
        s1_dt[i]   <= '0;
        s1_tag[i]  <= '0;
        s2_dt[i]   <= '0;
        s2_tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (iCLR) begin
        ent_valid <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (s1_wake[i]) begin
            s1_rdy[i] <= 1'b1;
            s1_dt[i]  <= s1_wdt[i];
          end
          if (s2_wake[i]) begin
            s2_rdy[i] <= 1'b1;
            s2_dt[i]  <= s2_wdt[i];
          end
        end
        if (iss_any) begin
          ent_valid[iss_idx] <= 1'b0;
        end
        if (dp_fire) begin
          ent_valid[free_idx] <= 1'b1;
          ent_pc[free_idx]    <= iDP_pc;
          ent_op[free_idx]    <= iDP_op;
          ent_imm[free_idx]   <= iDP_imm;
          ent_rd[free_idx]    <= iDP_rd_nick;
          s1_rdy[free_idx]    <= dp1_rdy;
          s1_dt[free_idx]     <= dp1_dt;
          s1_tag[free_idx]    <= iDP_rs1_nick;
          s2_rdy[free_idx]    <= dp2_rdy;
          s2_dt[free_idx]     <= dp2_dt;
          s2_tag[free_idx]    <= iDP_rs2_nick;
        end
      end
    end
  end

  assign occ_next = occ + CW'(dp_fire) - CW'(iss_any);

  // Issue register: data outputs hold between issues, only oRS_en drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ         <= '0;
      oRS_full    <= 1'b0;
      oRS_en      <= 1'b0;
      oRS_pc      <= '0;
      oRS_op      <= '0;
      oRS_imm     <= '0;
      oRS_rd_nick <= '0;
      oRS_rs1_dt  <= '0;
      oRS_rs2_dt  <= '0;
    end else if (rdy) begin
      if (iCLR) begin
        occ      <= '0;
        oRS_full <= 1'b0;
        oRS_en   <= 1'b0;
      end else begin
        occ      <= occ_next;
        oRS_full <= (occ_next == CW'(DEPTH));
        oRS_en   <= iss_any;
        if (iss_any) begin
          oRS_pc      <= ent_pc[iss_idx];
          oRS_op      <= ent_op[iss_idx];
          oRS_imm     <= ent_imm[iss_idx];
          oRS_rd_nick <= ent_rd[iss_idx];
          oRS_rs1_dt  <= s1_dt[iss_idx];
          oRS_rs2_dt  <= s2_dt[iss_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed dispatch/wakeup sequences push expected issues, a negedge monitor pops them.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        iCLR;
  logic        iDP_en;
  logic [31:0] iDP_pc;
  logic [5:0]  iDP_op;
  logic [31:0] iDP_imm;
  logic [3:0]  iDP_rd_nick;
  logic        iDP_rs1_rdy;
  logic [31:0] iDP_rs1_dt;
  logic [3:0]  iDP_rs1_nick;
  logic        iDP_rs2_rdy;
  logic [31:0] iDP_rs2_dt;
  logic [3:0]  iDP_rs2_nick;
  logic        iEX_en;
  logic [3:0]  iEX_nick;
  logic [31:0] iEX_dt;
  logic        iLSB_en;
  logic [3:0]  iLSB_nick;
  logic [31:0] iLSB_dt;
  logic        oRS_full;
  logic        oRS_en;
  logic [31:0] oRS_pc;
  logic [5:0]  oRS_op;
  logic [31:0] oRS_imm;
  logic [3:0]  oRS_rd_nick;
  logic [31:0] oRS_rs1_dt;
  logic [31:0] oRS_rs2_dt;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } iss_t;

  iss_t sb_q[$];
  iss_t mon_act;
  iss_t mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  logic rdy_q = 1'b0;

  alu_issue_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iCLR(iCLR),
    .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm), .iDP_rd_nick(iDP_rd_nick),
    .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
    .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
    .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
    .iLSB_en(iLSB_en), .iLSB_nick(iLSB_nick), .iLSB_dt(iLSB_dt),
    .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op), .oRS_imm(oRS_imm),
    .oRS_rd_nick(oRS_rd_nick), .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A held oRS_en while rdy was low is not a new issue, so only count edges taken with rdy high.
  always @(posedge clk) rdy_q <= rdy;

  always @(negedge clk) begin
    if (rst_n && rdy_q && oRS_en) begin
      mon_act = {oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt};
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL issue_unexpected: got pc=%h rd=%h rs1=%h rs2=%h, required no issue",
                 oRS_pc, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("[TB] FAIL issue_data: got pc=%h op=%h imm=%h rd=%h rs1=%h rs2=%h, required pc=%h op=%h imm=%h rd=%h rs1=%h rs2=%h",
                   mon_act.pc, mon_act.op, mon_act.imm, mon_act.rd, mon_act.rs1, mon_act.rs2,
                   mon_exp.pc, mon_exp.op, mon_exp.imm, mon_exp.rd, mon_exp.rs1, mon_exp.rs2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iDP_en  = 1'b0;
    iEX_en  = 1'b0;
    iLSB_en = 1'b0;
    iCLR    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                               input logic [3:0] rd, input logic r1_rdy, input logic [31:0] r1_dt,
                               input logic [3:0] r1_nick, input logic r2_rdy, input logic [31:0] r2_dt,
                               input logic [3:0] r2_nick);
    iDP_en       = 1'b1;
    iDP_pc       = pc;
    iDP_op       = op;
    iDP_imm      = imm;
    iDP_rd_nick  = rd;
    iDP_rs1_rdy  = r1_rdy;
    iDP_rs1_dt   = r1_dt;
    iDP_rs1_nick = r1_nick;
    iDP_rs2_rdy  = r2_rdy;
    iDP_rs2_dt   = r2_dt;
    iDP_rs2_nick = r2_nick;
  endtask

  task automatic bcastEx(input logic [3:0] nick, input logic [31:0] dt);
    iEX_en   = 1'b1;
    iEX_nick = nick;
    iEX_dt   = dt;
  endtask

  task automatic bcastLsb(input logic [3:0] nick, input logic [31:0] dt);
    iLSB_en   = 1'b1;
    iLSB_nick = nick;
    iLSB_dt   = dt;
  endtask

  task automatic expectIssue(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                             input logic [3:0] rd, input logic [31:0] rs1, input logic [31:0] rs2);
    sb_q.push_back({pc, op, imm, rd, rs1, rs2});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  logic [31:0] first_pc;
  logic [31:0] second_pc;

  initial begin
    rst_n = 1'b1;
    rdy   = 1'b1;
    idle();
    applyStimulus('0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    iDP_en = 1'b0;
    bcastEx('0, '0);
    bcastLsb('0, '0);
    idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_en", 32'(oRS_en), 32'd0);
    checkOutput("rst_full", 32'(oRS_full), 32'd0);
    checkOutput("rst_pc", oRS_pc, 32'd0);
    checkOutput("rst_rs1", oRS_rs1_dt, 32'd0);
    rst_n = 1'b1;

    // Both sources ready: issue two edges after dispatch.
    applyStimulus(32'h100, 6'h01, 32'h0, 4'd5, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    expectIssue(32'h100, 6'h01, 32'h0, 4'd5, 32'd5, 32'd7);
    tick(); idle();
    checkOutput("add_lat0", 32'(oRS_en), 32'd0);
    tick();
    checkOutput("add_en", 32'(oRS_en), 32'd1);
    checkOutput("add_rs1", oRS_rs1_dt, 32'd5);
    checkOutput("add_rs2", oRS_rs2_dt, 32'd7);
    checkOutput("add_rd", 32'(oRS_rd_nick), 32'd5);
    tick();
    checkOutput("add_pulse", 32'(oRS_en), 32'd0);

    // rs1 waits on tag 3, woken by EX two cycles after dispatch.
    applyStimulus(32'h104, 6'h02, 32'h4, 4'd6, 1'b0, 32'hDEAD, 4'd3, 1'b1, 32'h22, 4'd0);
    expectIssue(32'h104, 6'h02, 32'h4, 4'd6, 32'h10, 32'h22);
    tick(); idle();
    tick();
    checkOutput("wake_pre", 32'(oRS_en), 32'd0);
    bcastEx(4'd3, 32'h10);
    tick(); idle();
    checkOutput("wake_edge", 32'(oRS_en), 32'd0);
    tick();
    checkOutput("wake_en", 32'(oRS_en), 32'd1);
    checkOutput("wake_rs1", oRS_rs1_dt, 32'h10);
    tick();

    // Same nick on EX and LSB: EX data wins for both sources.
    applyStimulus(32'h108, 6'h03, 32'h0, 4'd7, 1'b0, 32'hDEAD, 4'd4, 1'b0, 32'hDEAD, 4'd4);
    expectIssue(32'h108, 6'h03, 32'h0, 4'd7, 32'hAAAA, 32'hAAAA);
    tick(); idle();
    bcastEx(4'd4, 32'hAAAA);
    bcastLsb(4'd4, 32'hBBBB);
    tick(); idle();
    tick();
    checkOutput("prio_en", 32'(oRS_en), 32'd1);
    checkOutput("prio_rs2", oRS_rs2_dt, 32'hAAAA);
    tick();

    // Dispatch-cycle bypass from LSB.
    applyStimulus(32'h10C, 6'h04, 32'h0, 4'd8, 1'b0, 32'hDEAD, 4'd9, 1'b1, 32'h1, 4'd0);
    bcastLsb(4'd9, 32'h99);
    expectIssue(32'h10C, 6'h04, 32'h0, 4'd8, 32'h99, 32'h1);
    tick(); idle();
    tick();
    checkOutput("byp_en", 32'(oRS_en), 32'd1);
    checkOutput("byp_rs1", oRS_rs1_dt, 32'h99);
    tick();

    // Fill all eight entries with rs1 waiting on tags 8..15.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h200 + 32'(4 * i), 6'h05, 32'(i), 4'(i), 1'b0, 32'hDEAD, 4'(8 + i),
                    1'b1, 32'h1000 + 32'(i), 4'd0);
      tick(); idle();
      checkOutput("full_fill", 32'(oRS_full), (i == 7) ? 32'd1 : 32'd0);
    end
    applyStimulus(32'h2FF, 6'h06, 32'h0, 4'd15, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    tick(); idle();
    checkOutput("full_drop", 32'(oRS_full), 32'd1);
    bcastEx(4'd11, 32'h33);
    expectIssue(32'h20C, 6'h05, 32'd3, 4'd3, 32'h33, 32'h1003);
    tick(); idle();
    checkOutput("full_wake_en", 32'(oRS_en), 32'd0);
    checkOutput("full_wake_full", 32'(oRS_full), 32'd1);
    tick();
    checkOutput("full_iss_en", 32'(oRS_en), 32'd1);
    checkOutput("full_iss_full", 32'(oRS_full), 32'd0);
    checkOutput("full_iss_pc", oRS_pc, 32'h20C);

    // Flush with an eligible entry and a concurrent dispatch: nothing survives.
    bcastEx(4'd8, 32'h80);
    tick(); idle();
    iCLR = 1'b1;
    applyStimulus(32'h2F0, 6'h06, 32'h0, 4'd1, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    tick(); idle();
    checkOutput("clr_en", 32'(oRS_en), 32'd0);
    checkOutput("clr_full", 32'(oRS_full), 32'd0);
    for (int t = 9; t < 16; t++) begin
      bcastEx(4'(t), 32'(t));
      tick(); idle();
    end
    tick();
    tick();
    checkOutput("clr_quiet", 32'(oRS_en), 32'd0);

    // Dispatch and issue in the same cycle; the freed slot is reused one cycle later.
    applyStimulus(32'h400, 6'h08, 32'h0, 4'd1, 1'b1, 32'h41, 4'd0, 1'b1, 32'h42, 4'd0);
    expectIssue(32'h400, 6'h08, 32'h0, 4'd1, 32'h41, 32'h42);
    tick();
    applyStimulus(32'h404, 6'h08, 32'h0, 4'd2, 1'b1, 32'h43, 4'd0, 1'b1, 32'h44, 4'd0);
    expectIssue(32'h404, 6'h08, 32'h0, 4'd2, 32'h43, 32'h44);
    tick();
    checkOutput("dpiss_en0", 32'(oRS_en), 32'd1);
    applyStimulus(32'h408, 6'h08, 32'h0, 4'd3, 1'b1, 32'h45, 4'd0, 1'b1, 32'h46, 4'd0);
    expectIssue(32'h408, 6'h08, 32'h0, 4'd3, 32'h45, 32'h46);
    tick(); idle();
    checkOutput("dpiss_pc1", oRS_pc, 32'h404);
    tick();
    checkOutput("dpiss_pc2", oRS_pc, 32'h408);
    tick();
    checkOutput("dpiss_idle", 32'(oRS_en), 32'd0);

    // Age ordering: A lands in entry 2, B later in entry 0, both woken together.
    applyStimulus(32'h500, 6'h07, 32'h0, 4'd1, 1'b0, 32'hDEAD, 4'd1, 1'b1, 32'h2, 4'd0);
    tick();
    applyStimulus(32'h504, 6'h07, 32'h0, 4'd2, 1'b0, 32'hDEAD, 4'd2, 1'b1, 32'h3, 4'd0);
    tick();
    applyStimulus(32'h508, 6'h07, 32'h0, 4'd10, 1'b0, 32'hDEAD, 4'd3, 1'b1, 32'h5, 4'd0);
    tick(); idle();
    bcastEx(4'd1, 32'h11);
    expectIssue(32'h500, 6'h07, 32'h0, 4'd1, 32'h11, 32'h2);
    tick(); idle();
    tick();
    checkOutput("age_x0", oRS_pc, 32'h500);
    applyStimulus(32'h50C, 6'h07, 32'h0, 4'd11, 1'b0, 32'hDEAD, 4'd5, 1'b1, 32'h6, 4'd0);
    tick(); idle();
    bcastEx(4'd3, 32'h0A);
    bcastLsb(4'd5, 32'h0B);
`ifdef ISSUE_OLDEST_EN
    expectIssue(32'h508, 6'h07, 32'h0, 4'd10, 32'h0A, 32'h5);
    expectIssue(32'h50C, 6'h07, 32'h0, 4'd11, 32'h0B, 32'h6);
    first_pc  = 32'h508;
    second_pc = 32'h50C;
`else
    expectIssue(32'h50C, 6'h07, 32'h0, 4'd11, 32'h0B, 32'h6);
    expectIssue(32'h508, 6'h07, 32'h0, 4'd10, 32'h0A, 32'h5);
    first_pc  = 32'h50C;
    second_pc = 32'h508;
`endif
    tick(); idle();
    tick();
    checkOutput("age_first", oRS_pc, first_pc);
    tick();
    checkOutput("age_second_en", 32'(oRS_en), 32'd1);
    checkOutput("age_second", oRS_pc, second_pc);
    bcastEx(4'd2, 32'h22);
    expectIssue(32'h504, 6'h07, 32'h0, 4'd2, 32'h22, 32'h3);
    tick(); idle();
    tick();
    checkOutput("age_x1", oRS_pc, 32'h504);
    tick();

    // rdy low freezes an eligible entry and ignores dispatch.
    applyStimulus(32'h600, 6'h09, 32'h0, 4'd4, 1'b1, 32'h61, 4'd0, 1'b1, 32'h62, 4'd0);
    expectIssue(32'h600, 6'h09, 32'h0, 4'd4, 32'h61, 32'h62);
    tick(); idle();
    rdy = 1'b0;
    applyStimulus(32'h6FF, 6'h09, 32'h0, 4'd9, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rdy_hold", 32'(oRS_en), 32'd0);
    end
    idle();
    rdy = 1'b1;
    tick();
    checkOutput("rdy_issue", 32'(oRS_en), 32'd1);
    checkOutput("rdy_pc", oRS_pc, 32'h600);
    tick();

    // Asynchronous reset while an issue is presented and an entry is pending.
    applyStimulus(32'h700, 6'h0A, 32'h0, 4'd5, 1'b0, 32'hDEAD, 4'd7, 1'b1, 32'h1, 4'd0);
    tick();
    applyStimulus(32'h704, 6'h0A, 32'h0, 4'd6, 1'b1, 32'h71, 4'd0, 1'b1, 32'h72, 4'd0);
    expectIssue(32'h704, 6'h0A, 32'h0, 4'd6, 32'h71, 32'h72);
    tick(); idle();
    tick();
    checkOutput("rstm_en_pre", 32'(oRS_en), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("rstm_en", 32'(oRS_en), 32'd0);
    checkOutput("rstm_pc", oRS_pc, 32'd0);
    checkOutput("rstm_rs2", oRS_rs2_dt, 32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(32'h708, 6'h0B, 32'h0, 4'd7, 1'b1, 32'h81, 4'd0, 1'b1, 32'h82, 4'd0);
    expectIssue(32'h708, 6'h0B, 32'h0, 4'd7, 32'h81, 32'h82);
    tick(); idle();
    bcastEx(4'd7, 32'h77);
    tick(); idle();
    checkOutput("rstm_first", oRS_pc, 32'h708);
    tick();
    tick();
    checkOutput("rstm_quiet", 32'(oRS_en), 32'd0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of reservation entries (power of two, 2..16).
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global enable; low freezes all state and outputs.
REQ-005 iCLR  in  1  flush (mispredict); invalidates every entry.
REQ-006 iDP_en  in  1  dispatch valid; iDP_pc 32, iDP_op 6, iDP_imm 32, iDP_rd_nick 4: instruction fields.
REQ-007 iDP_rs1_rdy  in  1, iDP_rs1_dt  in  32, iDP_rs1_nick  in  4: rs1 value if ready, else producer tag; identical rs2 set.
REQ-008 iEX_en  in  1, iEX_nick  in  4, iEX_dt  in  32: ALU result broadcast.
REQ-009 iLSB_en  in  1, iLSB_nick  in  4, iLSB_dt  in  32: load result broadcast.
REQ-010 oRS_full  out  1  registered; high when occupancy == DEPTH.
REQ-011 oRS_en  out  1, plus oRS_pc 32, oRS_op 6, oRS_imm 32, oRS_rd_nick 4, oRS_rs1_dt 32, oRS_rs2_dt 32: issue to ALU, registered.

Function
REQ-012 Entry: valid, op/pc/imm/rd_nick, per-source ready bit, 32-bit value, 4-bit tag.
REQ-013 Dispatch with iDP_en & !oRS_full writes the lowest-index free entry at the next edge.
REQ-014 Dispatch while oRS_full is ignored; no state changes.
REQ-015 Wakeup: each valid, not-ready source whose tag equals an asserted broadcast nick captures that data and sets ready at the edge.
REQ-016 Same-cycle dispatch bypass: a dispatched source with rdy=0 whose tag matches a broadcast this cycle is written ready with the broadcast data.
REQ-017 iEX and iLSB with equal nick in one cycle: iEX data wins.
REQ-018 Issue: at most one per cycle; eligible = valid & both sources ready, evaluated on registered state only; woken at edge t, issuable from cycle t+1.
REQ-019 Issued entry freed at the same edge that loads oRS_*; oRS_en high exactly one cycle per issue; oRS_en=0 when none eligible (data outputs hold).
REQ-020 Issue latency: eligible at registered state in cycle t -> oRS_en high in cycle t+1.
REQ-021 Simultaneous dispatch and issue in one cycle both occur; freed slot is not reusable until next cycle; oRS_full recomputed from resulting occupancy.
REQ-022 Occupancy counter: +1 dispatch, -1 issue, net 0 for both; never wraps.
REQ-023 iCLR (with rdy): all valid bits, occupancy, oRS_full, oRS_en cleared at the edge; dispatch and issue that cycle are discarded.
REQ-024 rdy=0: no dispatch, wakeup, issue or clear; oRS_en holds its value.

Reset
REQ-025 rst_n low: all entries invalid, occupancy 0, oRS_full 0, oRS_en 0, all oRS data outputs 0, age state cleared, immediately and asynchronously.
REQ-026 Reset mid-operation discards all entries; first dispatch accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ISSUE_OLDEST_EN defined: DEPTH x DEPTH age matrix; issue selects the oldest eligible entry in dispatch order.
REQ-028 ISSUE_OLDEST_EN undefined: no age matrix; issue selects the lowest-index eligible entry; all other behaviour identical.

Verification
REQ-029 Reset, dispatch ADD, rs1=5, rs2=7 both ready -> oRS_en one cycle, two edges after dispatch, rs1_dt=5, rs2_dt=7, rd_nick echoed.
REQ-030 Dispatch rs1 tag 3 not ready; iEX_en nick 3 data 0x10 two cycles later -> issue the cycle after wakeup edge, oRS_rs1_dt=0x10.
REQ-031 Fill 8 entries with unready sources -> oRS_full=1; 9th dispatch dropped; wake one -> issues, oRS_full=0 next cycle.
REQ-032 With ISSUE_OLDEST_EN: dispatch A into entry 2, B into entry 0 (after freeing 0), wake both same cycle -> A issues first, B next cycle; without macro B first.
REQ-033 Four entries pending, assert iCLR -> next cycle oRS_en=0, oRS_full=0, occupancy 0; later broadcasts cause no issue.
REQ-034 rdy low for 3 cycles with an eligible entry -> no issue; issue one cycle after rdy returns high; rst_n pulse mid-stream -> all outputs 0 asynchronously.
